// File: rtl/debounce_pulse_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// the default prescaler width.
package debounce_pulse_pkg;

    // 2^19 clk cycles is roughly 10.5 ms at 50 MHz.
    localparam int unsigned CntWDefault = 19;

    typedef enum logic [2:0] {
        StZero   = 3'd0,
        StWait11 = 3'd1,
        StWait12 = 3'd2,
        StWait13 = 3'd3,
        StOne    = 3'd4,
        StWait01 = 3'd5,
        StWait02 = 3'd6,
        StWait03 = 3'd7
    } state_e;

    // ONE and every WAIT0_x state sit in the upper half of the encoding, so the
    // debounced level is simply the state MSB.
    function automatic logic is_high_level(state_e s);
        return s[2];
    endfunction

endpackage

// File: rtl/debounce_pulse_tick_gen.sv
// Free-running prescaler: m_tick is high for the single cycle in which the
// count is all-ones, i.e. once every 2^CNT_W clk cycles.
module tick_gen
    import debounce_pulse_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic clk,
    input  logic reset,
    output logic m_tick
);

    logic [CNT_W-1:0] cnt_q;

    // Up-counter wrapping naturally; never restarted by anything but reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Combinational decode of the terminal count.
    always_comb begin
        m_tick = &cnt_q;
    end

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: two-flop synchronizer, sampling prescaler and a
// debounce FSM that needs three stable sample ticks to accept a level change.
// db_tick pulses once per accepted press; db_level is the clean level.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db_level,
    output logic db_tick
);

    logic   s1_q, s2_q;
    logic   m_tick;
    state_e state_q, state_d;
    logic   tick_q, tick_d;

    tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .m_tick (m_tick)
    );

    // Synchronize the asynchronous button; the FSM only ever looks at s2_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StZero;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic; a return to the prior level beats a coincident m_tick.
    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        case (state_q)
            StZero: begin
                if (s2_q) state_d = StWait11;
            end
            StWait11: begin
                if (!s2_q)       state_d = StZero;
                else if (m_tick) state_d = StWait12;
            end
            StWait12: begin
                if (!s2_q)       state_d = StZero;
                else if (m_tick) state_d = StWait13;
            end
            StWait13: begin
                if (!s2_q) begin
                    state_d = StZero;
                end else if (m_tick) begin
                    state_d = StOne;
                    tick_d  = 1'b1;
                end
            end
            StOne: begin
                if (!s2_q) state_d = StWait01;
            end
            StWait01: begin
                if (s2_q)        state_d = StOne;
                else if (m_tick) state_d = StWait02;
            end
            StWait02: begin
                if (s2_q)        state_d = StOne;
                else if (m_tick) state_d = StWait03;
            end
            StWait03: begin
                if (s2_q)        state_d = StOne;
                else if (m_tick) state_d = StZero;
            end
            default: begin
                state_d = StZero;
            end
        endcase
    end

    // Outputs come straight from registers, so they are glitch-free.
    always_comb begin
        db_level = is_high_level(state_q);
        db_tick  = tick_q;
    end

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Conditions a raw mechanical push-button input into clean control signals for the downstream N-bit enable counter.
- Sits directly upstream of that counter: two-flop synchronizer, then a sampling prescaler, then a debounce FSM.
- db_tick is a single-cycle pulse on each debounced press and drives the counter's en input, giving one count per press.
- db_level is the clean debounced button level, used for status LEDs.

Parameters:
- CNT_W, default 19: prescaler width. The sample tick period is 2^CNT_W clk cycles (~10.5 ms at 50 MHz). Benches use 3.
- N_SAMPLES, fixed at 3: consecutive stable sample ticks required to accept a level change. Not overridable; the FSM is hard-coded to it.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- btn, input, 1: raw asynchronous push-button level; 1 = pressed.
- db_level, output, 1: debounced level; 1 while the FSM is in ONE or any WAIT0_x state.
- db_tick, output, 1: one-clk pulse when a press is accepted; connects to the counter's en.

Behaviour:
- Reset: one clk has reset=1 -> on the next edge the block clears every register:
  - synchronizer flops = 0
  - prescaler = 0
  - state = ZERO
  - db_level = 0, db_tick = 0
- Reset overrides all other activity, including mid-debounce (any WAIT state) and a pulse in flight. No pulse is emitted because of reset.
- Synchronizer:
  - btn -> s1 -> s2, two flops. The FSM sees only s2.
  - Latency from btn to s2 is 2 clks.
- Prescaler:
  - Free-running CNT_W-bit up-counter that wraps naturally to 0.
  - m_tick = 1 combinationally for exactly the one cycle in which the count equals all-ones.
  - With reset released at cycle 0, m_tick is high during cycles 2^CNT_W-1, 2*2^CNT_W-1, and so on.
  - The prescaler never stops and is not restarted by btn activity.
- FSM states: ZERO, WAIT1_1, WAIT1_2, WAIT1_3, ONE, WAIT0_1, WAIT0_2, WAIT0_3.
  - ZERO: s2=1 -> WAIT1_1 on the next edge, with no m_tick needed. Otherwise stay.
  - WAIT1_k (k=1,2):
    - s2=0 -> ZERO.
    - else m_tick -> WAIT1_(k+1).
    - else stay.
  - WAIT1_3:
    - s2=0 -> ZERO.
    - else m_tick -> ONE, and db_tick=1 on that same edge.
    - else stay.
  - ONE: s2=0 -> WAIT0_1. Otherwise stay.
  - WAIT0_k (k=1,2):
    - s2=1 -> ONE, with no pulse.
    - else m_tick -> WAIT0_(k+1).
    - else stay.
  - WAIT0_3:
    - s2=1 -> ONE, with no pulse.
    - else m_tick -> ZERO.
    - else stay.
- Simultaneous events: in any WAIT state where s2 has returned to the prior level and m_tick=1 in the same cycle, the level check wins and the abort transition is taken.
- db_tick:
  - Registered; equals 1 only in the cycle immediately after the WAIT1_3 -> ONE edge.
  - Exactly one pulse per accepted press, never two consecutive high cycles.
  - No pulse on release.
  - No pulse on a bounce back into ONE from WAIT0_x.
- db_level: decoded from the state register, so it is glitch-free and registered.
- Acceptance latency: a stable press is accepted between 2+2*2^CNT_W+1 and 2+3*2^CNT_W clks after btn rises.
- Unused state encodings: next state = ZERO, db_tick = 0.

Decomposition:
- Shared package/header holds:
  - the 3-bit state encodings: ZERO=0, WAIT1_1=1, WAIT1_2=2, WAIT1_3=3, ONE=4, WAIT0_1=5, WAIT0_2=6, WAIT0_3=7
  - the CNT_W default
- One natural sub-module: tick_gen, which contains the prescaler.
  - Parameter: CNT_W.
  - Ports: clk, reset, m_tick.
  - Reusable for the display refresh logic elsewhere in the design.
- The synchronizer and FSM stay in debounce_pulse.

Test Plan (all scenarios use CNT_W=3, so m_tick occurs every 8 clks):
1. Reset check: hold reset for 2 clks, with btn=1 during reset -> db_level=0 and db_tick=0 while reset=1, and the state reads ZERO.
2. Clean press: reset, then btn 0->1 at cycle 10 and held -> exactly one db_tick pulse between cycle 29 and cycle 36; db_level=1 from that cycle onward; no further pulses while btn is held for 100 clks.
3. Bounce reject: btn toggles 1/0 every 5 clks for 60 clks, then is held at 0 -> no db_tick and db_level stays 0 throughout.
4. Release with bounce: starting from ONE, btn drops to 0, returns to 1 after 6 clks, then drops again and is held at 0 -> db_level stays 1 until 3 more m_ticks after the final drop, then goes to 0; zero db_tick pulses in total.
5. Reset mid-debounce: reset asserted while the state is WAIT1_2 -> state is ZERO and outputs are 0 on the next edge; btn still held at 1 -> a fresh acceptance yields exactly one pulse, with the full latency counted from reset release.
6. Counter integration: drive debounce_pulse.db_tick into the 4-bit enable counter and perform 17 clean presses -> counter q reads 1 (the count wraps past 15).
